vga_fb_arbiter: RTL and testbench
=================================

# vga_fb_arbiter

Arbitrates the single-port framebuffer RAM between the display fetch path, which is paced by the VGA timing generator, and a host read/write port. Display reads have absolute priority and a fixed latency, so the pixel pipeline never stalls. The host gets every remaining slot and can optionally be restricted to writing only during vertical blanking, to avoid tearing. It sits between the timing/pixel logic and the framebuffer RAM, and also reports host starvation.

## Interface
- ADDR_W, 13, framebuffer address width
- DATA_W, 8, framebuffer word width
- WR_IN_BLANK_ONLY, 1, if 1, host writes are granted only while `vblank`=1; host reads are unrestricted
- HOST_MAX_WAIT, 64, host wait cycles (req high, no ack) that sets `host_starve`; legal range 1..65535
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- vblank  in  1  vertical blanking from the timing generator
- disp_req  in  1  single-cycle display read request
- disp_addr  in  ADDR_W  display read address, sampled with `disp_req`
- disp_valid  out  1  display read data valid
- disp_rdata  out  DATA_W  display read data
- host_req  in  1  host request, held until `host_ack`
- host_we  in  1  1 = write, 0 = read; stable while `host_req` is high
- host_addr  in  ADDR_W  host address
- host_wdata  in  DATA_W  host write data
- host_ack  out  1  one-cycle grant
- host_rvalid  out  1  host read data valid
- host_rdata  out  DATA_W  host read data
- host_starve  out  1  sticky starvation flag
- starve_clr  in  1  clears `host_starve` and `wait_max`
- wait_max  out  16  longest host wait observed, saturating
- mem_addr  out  ADDR_W  RAM address, registered
- mem_we  out  1  RAM write enable, registered
- mem_wdata  out  DATA_W  RAM write data, registered
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after the address

## Operation
- Every cycle t, exactly one owner is chosen: DISP, HOST or NONE. The RAM command is registered, so it appears at t+1.
- Priority order:
  - DISP wins if `disp_req`=1.
  - Otherwise HOST wins if `host_req`=1, `host_ack`=0 this cycle, and the request is eligible.
  - A write is eligible only when WR_IN_BLANK_ONLY=0 or `vblank`=1. A read is always eligible.
- DISP grant: `mem_addr`=`disp_addr` and `mem_we`=0 at t+1.
- HOST grant:
  - `host_ack`=1 at t+1.
  - `mem_addr`=`host_addr` at t+1.
  - `mem_we`=`host_we` and `mem_wdata`=`host_wdata` at t+1.
- NONE: `mem_we`=0; `mem_addr` holds its previous value.
- The owner of each issued read is carried in a 2-stage tag pipeline with tags NONE, DISP and HOST_RD. Host writes are tagged NONE.
- Read return at t+2:
  - Tag DISP: `disp_valid`=1.
  - Tag HOST_RD: `host_rvalid`=1.
  - `disp_rdata` and `host_rdata` both pass `mem_rdata` through combinationally. Their contents are undefined when the corresponding valid is 0.
- `host_req` is ignored in any cycle where `host_ack`=1. This prevents a double grant of a request that is still held.
- Wait counter:
  - Increments each cycle `host_req`=1 and no grant is made; clears on grant.
  - `wait_max` latches the counter when it exceeds the current maximum; saturates at 0xFFFF.
  - `host_starve` sets when the counter reaches HOST_MAX_WAIT.
- `starve_clr`=1 clears `host_starve` and `wait_max`. If a starvation event occurs in the same cycle, set wins.

## Timing
- Reset value of every output is 0. On reset assertion, in-flight tags are flushed; no valid pulse follows for any pre-reset read.
- Display read latency: exactly 2 cycles from `disp_req` to `disp_valid`, under every condition.
- Host latency with no contention: `host_ack` 1 cycle after `host_req`; `host_rvalid` 2 cycles after `host_req`.
- Back-to-back `disp_req` on every cycle is legal. The host then waits until a cycle with no `disp_req` occurs.
- Host write pending when `vblank` falls to 0 (WR_IN_BLANK_ONLY=1): the write stays pending and is not acked until the next blank. A read presented after it is blocked, because the request is held and ordering is kept.
- `vblank` and `host_req` rising in the same cycle: the write is eligible that cycle.

## Structure
- Shared package `vga_pkg`:
  - enum `fb_owner_t` {OWN_NONE, OWN_DISP, OWN_HOST_RD}
  - constant `FB_RD_LAT`=2
- Sub-module `fb_tag_pipe`: parameterised depth FB_RD_LAT, shifts `fb_owner_t`, asynchronous flush on reset. Everything else is flat in `vga_fb_arbiter`.

## Test plan
- Reset, then idle: all outputs 0. Host read at addr 0x010 with RAM model 0x5A → `host_ack` at +1, `host_rvalid`=1 with `host_rdata`=0x5A at +2.
- `disp_req` every cycle for 100 cycles while `host_req` (read) is held → `disp_valid` every cycle at +2, no `host_ack`, `host_starve`=1 after 64 cycles, `wait_max`=100. Host granted in the first free cycle.
- WR_IN_BLANK_ONLY=1, host write 0xA5 to 0x100 with `vblank`=0 → no ack. Raise `vblank` → ack the next cycle, RAM[0x100]=0xA5.
- Alternating `disp_req` (addr 1, 2, 3) and host reads (addr 9) → disp data order 1, 2, 3 and each host read returned on the correct tag; never a double ack for one held request.
- Assert `reset_n` low one cycle after `disp_req` → no `disp_valid` afterwards; all outputs 0.
- `starve_clr` pulsed in the same cycle a starvation event occurs → `host_starve` remains 1.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA framebuffer arbiter.
package vga_pkg;

  // Owner of a RAM read slot, carried alongside the read until its data returns.
  typedef enum logic [1:0] {
    OWN_NONE    = 2'd0,
    OWN_DISP    = 2'd1,
    OWN_HOST_RD = 2'd2
  } fb_owner_t;

  // Cycles from a granted read request to its returned data.
  localparam int FB_RD_LAT = 2;

  // 16-bit increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Host read/write port of the framebuffer arbiter.
//
// Handshake: the host raises host_req with host_we/host_addr/host_wdata and
// holds all of them stable until it sees host_ack high for one cycle; host_req
// is ignored in that ack cycle, so the host may keep it high there and drop it
// (or present the next request) afterwards. For a read, host_rvalid pulses one
// cycle after host_ack, with host_rdata valid only in that cycle.
interface vga_fb_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
);
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ack;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;

  modport master (
    output host_req, host_we, host_addr, host_wdata,
    input  host_ack, host_rvalid, host_rdata
  );

  modport slave (
    input  host_req, host_we, host_addr, host_wdata,
    output host_ack, host_rvalid, host_rdata
  );
endinterface

// File: rtl/fb_tag_pipe.sv
// Shift register carrying the owner tag of each issued RAM read until the
// cycle its data comes back; reset flushes every in-flight tag.
module fb_tag_pipe
  import vga_pkg::*;
#(
  parameter int DEPTH = FB_RD_LAT
) (
  input  logic      clk,
  input  logic      reset_n,
  input  fb_owner_t tag_in,
  output fb_owner_t tag_out
);

  fb_owner_t stage [DEPTH];

  // Shift tags one stage per cycle; asynchronous reset empties the pipe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= OWN_NONE;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: display reads always win and return with a
// fixed latency; the host takes the remaining slots (writes optionally only in
// vertical blanking) and its waiting time is tracked for starvation reporting.
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int ADDR_W           = 13,
  parameter int DATA_W           = 8,
  parameter bit WR_IN_BLANK_ONLY = 1'b1,
  parameter int HOST_MAX_WAIT    = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vblank,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_rdata,
  vga_fb_arbiter_if.slave   host,
  output logic              host_starve,
  input  logic              starve_clr,
  output logic [15:0]       wait_max,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [15:0] MAX_WAIT = 16'(HOST_MAX_WAIT);

  logic        host_ack_q;
  logic        host_eligible;
  logic        host_grant;
  logic        host_waiting;
  logic        starve_evt;
  logic [15:0] wait_cnt;
  logic [15:0] wait_nxt;
  fb_owner_t   issue_tag;
  fb_owner_t   return_tag;

  // A held request is ignored during its own ack cycle to avoid a double grant;
  // writes may additionally be held off until vertical blanking.
  assign host_eligible = host.host_req && !host_ack_q &&
                         (!host.host_we || !WR_IN_BLANK_ONLY || vblank);

  // Pick this cycle's owner: display first, then an eligible host request.
  always_comb begin
    host_grant = 1'b0;
    issue_tag  = OWN_NONE;
    if (disp_req) begin
      issue_tag = OWN_DISP;
    end else if (host_eligible) begin
      host_grant = 1'b1;
      issue_tag  = host.host_we ? OWN_NONE : OWN_HOST_RD;
    end
  end

  // Register the RAM command of the winning owner; idle cycles keep the address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      host_ack_q <= 1'b0;
    end else begin
      host_ack_q <= host_grant;
      if (disp_req) begin
        mem_addr <= disp_addr;
        mem_we   <= 1'b0;
      end else if (host_grant) begin
        mem_addr  <= host.host_addr;
        mem_we    <= host.host_we;
        mem_wdata <= host.host_wdata;
      end else begin
        mem_we <= 1'b0;
      end
    end
  end

  fb_tag_pipe #(.DEPTH(FB_RD_LAT)) u_tag_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .tag_in  (issue_tag),
    .tag_out (return_tag)
  );

  // Returned data goes to whichever side owns the slot; the other sees zero.
  always_comb begin
    disp_valid       = (return_tag == OWN_DISP);
    host.host_rvalid = (return_tag == OWN_HOST_RD);
    disp_rdata       = disp_valid ? mem_rdata : '0;
    host.host_rdata  = host.host_rvalid ? mem_rdata : '0;
  end

  assign host.host_ack = host_ack_q;

  // Wait accounting: a pending host request that was neither granted nor
  // being acked counts as one wait cycle.
  always_comb begin
    host_waiting = host.host_req && !host_ack_q && !host_grant;
    wait_nxt     = wait_cnt;
    if (host_grant)        wait_nxt = '0;
    else if (host_waiting) wait_nxt = sat_inc16(wait_cnt);
    starve_evt = host_waiting && (wait_cnt == MAX_WAIT - 16'd1);
  end

  // Wait counter, its running maximum and the sticky starvation flag; a
  // starvation event beats a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt    <= '0;
      wait_max    <= '0;
      host_starve <= 1'b0;
    end else begin
      wait_cnt <= wait_nxt;
      if (starve_clr)               wait_max <= '0;
      else if (wait_nxt > wait_max) wait_max <= wait_nxt;
      if (starve_evt)      host_starve <= 1'b1;
      else if (starve_clr) host_starve <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: directed scenarios followed by random traffic,
// all checked cycle by cycle against a slot-schedule reference model.
module tb_vga_fb_arbiter;

  localparam int ADDR_W  = 13;
  localparam int DATA_W  = 8;
  localparam bit WR_ONLY = 1'b1;
  localparam int MAXW    = 64;

  // ---------------- clock / reset / signals ----------------
  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              vblank = 1'b0;
  logic              disp_req = 1'b0;
  logic [ADDR_W-1:0] disp_addr = '0;
  logic              disp_valid;
  logic [DATA_W-1:0] disp_rdata;
  logic              host_starve;
  logic              starve_clr = 1'b0;
  logic [15:0]       wait_max;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  always #5 clk = ~clk;

  vga_fb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) hif ();

  vga_fb_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .WR_IN_BLANK_ONLY(WR_ONLY), .HOST_MAX_WAIT(MAXW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .vblank(vblank),
    .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_valid(disp_valid), .disp_rdata(disp_rdata),
    .host(hif),
    .host_starve(host_starve), .starve_clr(starve_clr), .wait_max(wait_max),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Framebuffer RAM: synchronous write, one-cycle registered read.
  logic [DATA_W-1:0] ram [0:8191];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // ---------------- scoreboard / reference model ----------------
  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  // Expected events per cycle slot (ring of 16 cycles).
  bit                r_ack [16];
  bit                r_dv  [16];
  bit                r_hv  [16];
  logic [DATA_W-1:0] r_hd  [16];
  bit                r_mv  [16];
  logic [ADDR_W-1:0] r_ma  [16];
  bit                r_mwe [16];
  logic [DATA_W-1:0] r_mwd [16];
  logic [DATA_W-1:0] exp_q [$];   // display data in request order
  logic [DATA_W-1:0] shadow [0:8191];

  int                m_wait, m_max;
  bit                m_starve;
  logic [ADDR_W-1:0] m_cur_addr;
  bit                ack_now;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) begin
      r_ack[i] = 0; r_dv[i] = 0; r_hv[i] = 0; r_mv[i] = 0;
      r_hd[i] = '0; r_ma[i] = '0; r_mwe[i] = 0; r_mwd[i] = '0;
    end
    exp_q.delete();
    m_wait = 0; m_max = 0; m_starve = 0; m_cur_addr = '0; ack_now = 0;
  endtask

  // Compare every output of the current cycle against the schedule.
  task automatic check_cycle();
    int s;
    logic [ADDR_W-1:0] ea;
    s = cyc % 16;
    ack_now = r_ack[s];
    chk("host_ack", hif.host_ack, r_ack[s]);
    chk("disp_valid", disp_valid, r_dv[s]);
    if (r_dv[s] && exp_q.size() > 0) chk("disp_rdata", disp_rdata, exp_q.pop_front());
    chk("host_rvalid", hif.host_rvalid, r_hv[s]);
    if (r_hv[s]) chk("host_rdata", hif.host_rdata, r_hd[s]);
    ea = r_mv[s] ? r_ma[s] : m_cur_addr;
    m_cur_addr = ea;
    chk("mem_addr", mem_addr, ea);
    chk("mem_we", mem_we, r_mv[s] && r_mwe[s]);
    if (r_mv[s] && r_mwe[s]) chk("mem_wdata", mem_wdata, r_mwd[s]);
    chk("host_starve", host_starve, m_starve);
    chk("wait_max", wait_max, m_max);
    r_ack[s] = 0; r_dv[s] = 0; r_hv[s] = 0; r_mv[s] = 0;
  endtask

  // Apply the arbitration rules to this cycle's inputs.
  task automatic model_cycle();
    int s1, s2;
    bit hgrant, evt;
    s1 = (cyc + 1) % 16;
    s2 = (cyc + 2) % 16;
    hgrant = 0;
    evt = 0;
    if (disp_req) begin
      r_mv[s1] = 1; r_ma[s1] = disp_addr; r_mwe[s1] = 0;
      r_dv[s2] = 1;
      exp_q.push_back(shadow[disp_addr]);
    end else if (hif.host_req && !ack_now && (!hif.host_we || !WR_ONLY || vblank)) begin
      hgrant = 1;
      r_ack[s1] = 1;
      r_mv[s1] = 1; r_ma[s1] = hif.host_addr; r_mwe[s1] = hif.host_we; r_mwd[s1] = hif.host_wdata;
      if (hif.host_we) shadow[hif.host_addr] = hif.host_wdata;
      else begin
        r_hv[s2] = 1;
        r_hd[s2] = shadow[hif.host_addr];
      end
    end
    if (hgrant) m_wait = 0;
    else if (hif.host_req && !ack_now && m_wait < 65535) begin
      m_wait++;
      if (m_wait == MAXW) evt = 1;
    end
    if (evt) m_starve = 1;
    else if (starve_clr) m_starve = 0;
    if (starve_clr) m_max = 0;
    else if (m_wait > m_max) m_max = m_wait;
  endtask

  // ---------------- driver tasks ----------------
  // One clock cycle: check, model, advance; the host drops its request after
  // the ack cycle.
  task automatic tick();
    @(negedge clk);
    check_cycle();
    model_cycle();
    @(posedge clk);
    #1;
    cyc++;
    if (ack_now) hif.host_req = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    disp_req = 1'b0; hif.host_req = 1'b0; starve_clr = 1'b0;
    #2;
    chk("rst_disp_valid", disp_valid, 0);
    chk("rst_disp_rdata", disp_rdata, 0);
    chk("rst_host_ack", hif.host_ack, 0);
    chk("rst_host_rvalid", hif.host_rvalid, 0);
    chk("rst_host_rdata", hif.host_rdata, 0);
    chk("rst_host_starve", host_starve, 0);
    chk("rst_wait_max", wait_max, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    clear_model();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic host_op(input bit we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input int budget);
    bit done;
    done = 0;
    hif.host_req = 1'b1; hif.host_we = we; hif.host_addr = a; hif.host_wdata = d;
    for (int i = 0; i < budget && !done; i++) begin
      tick();
      if (ack_now) done = 1;
    end
    chk("host_op_done", done, 1);
    hif.host_req = 1'b0;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int n;
    bit seen;
    hif.host_req = 1'b0; hif.host_we = 1'b0; hif.host_addr = '0; hif.host_wdata = '0;
    for (int i = 0; i < 8192; i++) begin
      ram[i] = 8'(i * 7 + 3);
      shadow[i] = ram[i];
    end
    ram[13'h010] = 8'h5A; shadow[13'h010] = 8'h5A;
    #1;
    do_reset();
    for (int i = 0; i < 3; i++) tick();

    // Uncontended host read: ack at +1, data at +2.
    hif.host_req = 1'b1; hif.host_we = 1'b0; hif.host_addr = 13'h010;
    tick();
    chk("read_ack_latency", hif.host_ack, 1);
    tick();
    chk("read_rvalid_latency", hif.host_rvalid, 1);
    chk("read_rdata_5a", hif.host_rdata, 8'h5A);
    for (int i = 0; i < 3; i++) tick();

    // Display every cycle for 100 cycles starves a held host read.
    hif.host_req = 1'b1; hif.host_we = 1'b0; hif.host_addr = 13'h020;
    disp_req = 1'b1;
    for (int i = 0; i < 100; i++) begin
      disp_addr = 13'($urandom_range(0, 8191));
      tick();
    end
    chk("starve_after_100", host_starve, 1);
    chk("wait_max_100", wait_max, 100);
    disp_req = 1'b0;
    n = 0;
    seen = 0;
    for (int i = 0; i < 4 && !seen; i++) begin
      tick();
      n++;
      if (hif.host_ack) seen = 1;
    end
    chk("first_free_grant", n, 1);
    tick(); tick(); tick();
    starve_clr = 1'b1;
    tick();
    starve_clr = 1'b0;
    chk("starve_cleared", host_starve, 0);
    chk("wait_max_cleared", wait_max, 0);

    // Blank-only write: held off outside vblank, acked once vblank rises.
    vblank = 1'b0;
    hif.host_req = 1'b1; hif.host_we = 1'b1; hif.host_addr = 13'h100; hif.host_wdata = 8'hA5;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen |= hif.host_ack;
    end
    chk("no_ack_outside_blank", seen, 0);
    vblank = 1'b1;
    tick();
    chk("ack_after_vblank", hif.host_ack, 1);
    for (int i = 0; i < 3; i++) tick();
    chk("ram_0x100", ram[13'h100], 8'hA5);
    host_op(1'b0, 13'h100, 8'h00, 4);
    for (int i = 0; i < 3; i++) tick();

    // Alternating display reads (1, 2, 3) and held host reads of address 9.
    for (int i = 0; i < 6; i++) begin
      disp_req = (i % 2 == 0);
      disp_addr = 13'(i / 2 + 1);
      if (!hif.host_req) begin
        hif.host_req = 1'b1; hif.host_we = 1'b0; hif.host_addr = 13'h009;
      end
      tick();
    end
    disp_req = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    hif.host_req = 1'b0;
    tick(); tick();

    // Reset one cycle after a display request flushes the pending return.
    disp_req = 1'b1; disp_addr = 13'h005;
    tick();
    disp_req = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) tick();

    // Clear coinciding with the starvation event: set wins.
    vblank = 1'b1;
    hif.host_req = 1'b1; hif.host_we = 1'b0; hif.host_addr = 13'h033;
    disp_req = 1'b1;
    for (int i = 0; i < MAXW - 1; i++) tick();
    chk("starve_before_event", host_starve, 0);
    starve_clr = 1'b1;
    tick();
    starve_clr = 1'b0;
    chk("starve_set_wins", host_starve, 1);
    disp_req = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    // Random traffic: light then heavy display load, toggling vblank.
    for (int i = 0; i < 1200; i++) begin
      disp_req = ($urandom_range(0, 99) < ((i < 600) ? 40 : 92));
      disp_addr = 13'($urandom_range(0, 31));
      if (!hif.host_req && $urandom_range(0, 3) == 0) begin
        hif.host_req = 1'b1;
        hif.host_we = 1'($urandom_range(0, 1));
        hif.host_addr = 13'($urandom_range(0, 31));
        hif.host_wdata = 8'($urandom);
      end
      if ($urandom_range(0, 49) == 0) vblank = ~vblank;
      starve_clr = ($urandom_range(0, 149) == 0);
      tick();
    end
    disp_req = 1'b0; starve_clr = 1'b0; vblank = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("exp_q_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
